pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle program-counter controller for the datapath's fetch/branch path. Owns the PC register and sequences each instruction: it fetches from instruction memory with a req/ack handshake, waits for the execute stage to resolve, and selects the next PC. The next PC is PC+4, or the branch target when `branch & alu_zero`. It also flags taken-branch redirects, counts taken branches, and traps on misaligned targets.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `CNT_W`, 16, width of the taken-branch counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high in FETCH.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory accepted the fetch; sampled only while `imem_req`=1.
- `instr_valid`  out  1  one-cycle pulse: the fetched instruction is valid for decode.
- `ex_done`  in  1  execute stage has resolved; `branch`, `alu_zero` and `branch_target` are valid. Held until accepted.
- `ex_ack`  out  1  sequencer accepts the resolution.
- `stall`  in  1  hazard hold; blocks acceptance of `ex_done`.
- `branch`  in  1  current instruction is a conditional branch.
- `alu_zero`  in  1  ALU zero flag.
- `branch_target`  in  32  precomputed target (PC + offset).
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc`+4, modulo 2^32.
- `redirect`  out  1  one-cycle pulse on a taken branch.
- `fault`  out  1  sticky misaligned-target trap.
- `taken_cnt`  out  CNT_W  number of taken branches.

## Operation
- States:
  - IDLE: after reset; goes to FETCH on the next cycle.
  - FETCH: `imem_req`=1. On `imem_ack`=1, go to EXEC.
  - EXEC: waits for the execute stage (see below).
  - TRAP: absorbing state; `fault`=1, `imem_req`=0, `ex_ack`=0. Only `rst_n` exits it.
- Handshake: `ex_ack` = (state==EXEC) & !`stall`, combinational. A transfer happens when `ex_done` & `ex_ack`.
- On a transfer:
  - taken = `branch` & `alu_zero`.
  - If taken and `branch_target[1:0]` != 0: go to TRAP; PC unchanged; `redirect` not asserted; counter unchanged.
  - Else: PC ← taken ? `branch_target` : `pc_plus4`; `redirect` pulses if taken; go to FETCH.
- `branch`=1 with `alu_zero`=0, and `branch`=0 with `alu_zero`=1, are both not taken.
- `taken_cnt` increments on each taken, aligned transfer and saturates at all-ones.
- PC wraps: `pc`=32'hFFFF_FFFC gives `pc_plus4`=0, and the next sequential PC is 0.
- `stall` in FETCH has no effect. A fetch in flight completes.

## Timing
- Reset values (while `rst_n`=0 at an edge): `pc`=RESET_PC, state IDLE, `imem_req`=0, `instr_valid`=0, `ex_ack`=0, `redirect`=0, `fault`=0, `taken_cnt`=0.
- Reset mid-fetch or in TRAP drops `imem_req` in the cycle after the reset edge. A pending `imem_ack` is then ignored.
- `imem_ack` may arrive in the same cycle `imem_req` rises, giving a 1-cycle FETCH. Any wait states are absorbed.
- `instr_valid` is registered: high in the first EXEC cycle only.
- A transfer in cycle N updates `pc` at the end of cycle N; `redirect` is registered, high in cycle N+1, and FETCH restarts in cycle N+1 with the new address.
- Minimum throughput is 2 cycles per instruction: FETCH with immediate ack, then EXEC with immediate `ex_done`.
- `branch`, `alu_zero` and `branch_target` are sampled only at the transfer edge.

## Structure
- Package `pc_seq_pkg`:
  - state enum (IDLE, FETCH, EXEC, TRAP)
  - `INSN_BYTES`=4
  - `ALIGN_MASK`=2'b11
- Sub-module `next_pc_sel`: combinational. Takes `pc_plus4`, `branch_target`, `branch` and `alu_zero`; produces next PC, taken and misaligned. The top level holds the FSM, PC, counter and pulse registers.

## Test plan
- Reset with RESET_PC=0x100, ack delayed 2 cycles, `ex_done` held with `branch`=0 for 3 instructions → fetch addresses 0x100, 0x104, 0x108; one `instr_valid` pulse per fetch; `taken_cnt`=0.
- `branch`=1, `alu_zero`=1, target 0x40 → `pc`=0x40, one `redirect` pulse, next `imem_addr`=0x40, `taken_cnt`=1. Repeat with `alu_zero`=0 → `pc`=pc+4, no redirect.
- `stall`=1 for 4 cycles while `ex_done`=1 → `ex_ack`=0 and PC held; transfer happens in the cycle `stall` falls.
- Taken branch to 0x42 → TRAP, `fault`=1, `pc` unchanged, no further `imem_req`. Then `rst_n`=0 for one edge → all reset values restored.
- RESET_PC=0xFFFF_FFFC, one not-taken instruction → next fetch at 0x0000_0000.
- CNT_W=2, 5 taken aligned branches → `taken_cnt` saturates at 3.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        TRAP
    } state_e;

    localparam int unsigned INSN_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: sequential vs. taken-branch target, with alignment trap.
module next_pc_sel
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] branch_target,
    input  logic        branch,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        misaligned
);

    assign taken      = branch & alu_zero;
    assign misaligned = taken & (|(branch_target[1:0] & ALIGN_MASK));
    assign next_pc    = taken ? branch_target : pc_plus4;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch handshake, execute resolution, next-PC update.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             ex_done,
    output logic             ex_ack,
    input  logic             stall,
    input  logic             branch,
    input  logic             alu_zero,
    input  logic [31:0]      branch_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             redirect,
    output logic             fault,
    output logic [CNT_W-1:0] taken_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ivalid_q, ivalid_d;
    logic             redir_q, redir_d;

    logic [31:0] next_pc;
    logic        taken;
    logic        misaligned;
    logic        xfer;

    assign pc_plus4 = pc_q + 32'(INSN_BYTES);

    next_pc_sel u_sel (
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .branch        (branch),
        .alu_zero      (alu_zero),
        .next_pc       (next_pc),
        .taken         (taken),
        .misaligned    (misaligned)
    );

    assign ex_ack = (state_q == EXEC) & ~stall;
    assign xfer   = ex_done & ex_ack;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        ivalid_d = 1'b0;
        redir_d  = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_d  = EXEC;
                    ivalid_d = 1'b1;
                end
            end
            EXEC: begin
                if (xfer) begin
                    if (misaligned) begin
                        state_d = TRAP;
                    end else begin
                        state_d = FETCH;
                        pc_d    = next_pc;
                        redir_d = taken;
                        // Counter saturates rather than wrapping.
                        if (taken && !(&cnt_q))
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            ivalid_q <= 1'b0;
            redir_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            ivalid_q <= ivalid_d;
            redir_q  <= redir_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = ivalid_q;
    assign redirect    = redir_q;
    assign fault       = (state_q == TRAP);
    assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer, checked against a behavioural reference.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic        ex_done = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] branch_target = '0;

    logic        a_req, a_iv, a_exack, a_redir, a_fault;
    logic [31:0] a_addr, a_pc, a_pc4;
    logic [15:0] a_cnt;
    logic        b_req, b_iv, b_exack, b_redir, b_fault;
    logic [31:0] b_addr, b_pc, b_pc4;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0100), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack),
        .instr_valid(a_iv), .ex_done(ex_done), .ex_ack(a_exack),
        .stall(stall), .branch(branch), .alu_zero(alu_zero),
        .branch_target(branch_target), .pc(a_pc), .pc_plus4(a_pc4),
        .redirect(a_redir), .fault(a_fault), .taken_cnt(a_cnt)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack),
        .instr_valid(b_iv), .ex_done(ex_done), .ex_ack(b_exack),
        .stall(stall), .branch(branch), .alu_zero(alu_zero),
        .branch_target(branch_target), .pc(b_pc), .pc_plus4(b_pc4),
        .redirect(b_redir), .fault(b_fault), .taken_cnt(b_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: instruction-level bookkeeping, one entry per configuration.
    logic [31:0] m_pc [2];
    int          m_cnt [2];
    int          cmax [2] = '{65535, 3};
    bit          m_started, m_fetch, m_exec, m_trap, m_redir;
    int          m_age;

    always @(posedge clk) begin
        bit tk;
        if (!rst_n) begin
            m_pc[0] = 32'h0000_0100;
            m_pc[1] = 32'hFFFF_FFFC;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_started = 0; m_fetch = 0; m_exec = 0; m_trap = 0;
            m_redir = 0; m_age = 0;
        end else begin
            m_redir = 0;
            if (m_trap) begin
                m_trap = 1;
            end else if (!m_started) begin
                m_started = 1;
                m_fetch = 1;
            end else if (m_fetch) begin
                if (imem_ack) begin
                    m_fetch = 0; m_exec = 1; m_age = 0;
                end
            end else if (m_exec) begin
                if (ex_done && !stall) begin
                    tk = branch && alu_zero;
                    m_exec = 0;
                    if (tk && branch_target[1:0] != 2'b00) begin
                        m_trap = 1;
                    end else begin
                        for (int k = 0; k < 2; k++) begin
                            m_pc[k] = tk ? branch_target : m_pc[k] + 32'd4;
                            if (tk && m_cnt[k] < cmax[k]) m_cnt[k]++;
                        end
                        m_redir = tk;
                        m_fetch = 1;
                    end
                end else begin
                    m_age++;
                end
            end
        end
    end

    logic [31:0] fq[$];
    int iv_cnt = 0;
    int redir_total = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_req", a_req, m_fetch);
            chk("a_addr", a_addr, m_pc[0]);
            chk("a_pc", a_pc, m_pc[0]);
            chk("a_pc4", a_pc4, m_pc[0] + 32'd4);
            chk("a_iv", a_iv, (m_exec && m_age == 0));
            chk("a_exack", a_exack, (m_exec && !stall));
            chk("a_redir", a_redir, m_redir);
            chk("a_fault", a_fault, m_trap);
            chk("a_cnt", {16'b0, a_cnt}, m_cnt[0]);
            chk("b_req", b_req, m_fetch);
            chk("b_pc", b_pc, m_pc[1]);
            chk("b_pc4", b_pc4, m_pc[1] + 32'd4);
            chk("b_iv", b_iv, (m_exec && m_age == 0));
            chk("b_exack", b_exack, (m_exec && !stall));
            chk("b_redir", b_redir, m_redir);
            chk("b_fault", b_fault, m_trap);
            chk("b_cnt", {30'b0, b_cnt}, m_cnt[1]);
            if (a_req && imem_ack) fq.push_back(a_addr);
            if (a_iv) iv_cnt++;
            if (a_redir) redir_total++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        logic [31:0] r;
        r = $urandom;
        branch = r[0];
        alu_zero = r[1];
        branch_target = $urandom;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!a_req) begin
            stall = 1'($urandom_range(0, 1));
            step();
            n++;
            if (n > 50) begin
                chk("req_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic do_insn(input int aw, input int ew, input bit br, input bit z,
                           input logic [31:0] tgt, input int sc);
        wait_req();
        repeat (aw) begin
            imem_ack = 1'b0;
            stall = 1'($urandom_range(0, 1));
            step();
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        stall = 1'b0;
        repeat (ew) begin
            scramble();
            stall = 1'($urandom_range(0, 1));
            step();
        end
        ex_done = 1'b1;
        branch = br;
        alu_zero = z;
        branch_target = tgt;
        repeat (sc) begin
            stall = 1'b1;
            step();
        end
        stall = 1'b0;
        step();
        ex_done = 1'b0;
        scramble();
    endtask

    logic [31:0] pc_before;

    initial begin
        rst_n = 1'b0;
        repeat (2) step();
        chk_on = 1'b1;
        chk("rst_pc_lit", a_pc, 32'h0000_0100);
        chk("rst_req_lit", a_req, 1'b0);
        rst_n = 1'b1;

        repeat (3) do_insn(2, 0, 1'b0, 1'b0, 32'h0000_0300, 0);
        chk("nfetch", fq.size(), 32'd3);
        if (fq.size() >= 3) begin
            chk("fetch0", fq[0], 32'h0000_0100);
            chk("fetch1", fq[1], 32'h0000_0104);
            chk("fetch2", fq[2], 32'h0000_0108);
        end
        chk("iv_pulses", iv_cnt, 32'd3);
        chk("cnt_zero", {16'b0, a_cnt}, 32'd0);

        do_insn(0, 0, 1'b1, 1'b1, 32'h0000_0040, 0);
        chk("br_pc", a_pc, 32'h0000_0040);
        chk("br_addr", a_addr, 32'h0000_0040);
        chk("br_redir", a_redir, 1'b1);
        chk("br_cnt", {16'b0, a_cnt}, 32'd1);
        do_insn(1, 1, 1'b1, 1'b0, 32'h0000_0080, 0);
        chk("nt_pc", a_pc, 32'h0000_0044);
        chk("nt_redir", a_redir, 1'b0);
        chk("redir_total", redir_total, 32'd1);

        do_insn(0, 0, 1'b0, 1'b1, 32'h0000_0000, 4);
        chk("stall_pc", a_pc, 32'h0000_0048);

        do_insn(0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 0);
        chk("wrap_pc4", a_pc4, 32'h0000_0000);
        do_insn(0, 0, 1'b0, 1'b0, 32'h0000_0010, 0);
        chk("wrap_pc", a_pc, 32'h0000_0000);
        chk("wrap_pc_b", b_pc, 32'h0000_0000);

        for (int i = 0; i < 5; i++)
            do_insn(0, 1, 1'b1, 1'b1, 32'h0000_0200 + 32'(i * 16), 0);
        chk("sat_b", {30'b0, b_cnt}, 32'd3);
        chk("cnt_a", {16'b0, a_cnt}, 32'd7);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] r;
            r = $urandom;
            do_insn($urandom_range(0, 3), $urandom_range(0, 3), r[0], r[1],
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
        end

        pc_before = a_pc;
        do_insn(0, 0, 1'b1, 1'b1, 32'h0000_0042, 0);
        chk("trap_fault", a_fault, 1'b1);
        chk("trap_pc", a_pc, pc_before);
        repeat (5) begin
            scramble();
            ex_done = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            step();
        end
        chk("trap_noreq", a_req, 1'b0);
        chk("trap_fault2", a_fault, 1'b1);
        ex_done = 1'b0;
        imem_ack = 1'b0;

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_pc", a_pc, 32'h0000_0100);
        chk("rst2_fault", a_fault, 1'b0);
        chk("rst2_cnt", {16'b0, a_cnt}, 32'd0);

        wait_req();
        stall = 1'b0;
        imem_ack = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midfetch_req", a_req, 1'b0);
        step();
        imem_ack = 1'b0;

        for (int i = 0; i < 20; i++) begin
            logic [31:0] r;
            r = $urandom;
            do_insn($urandom_range(0, 2), $urandom_range(0, 2), r[0], r[1],
                    $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
        end
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
